// File: rtl/ecg_pkg.sv
// Shared types and defaults for the token / positional-embedding streamer.
// Elements are signed Q4.4 bytes; the stream FSM walks IDLE -> CAPT -> STREAM -> DONE.
package ecg_pkg;

  // Default geometry of one frame: 15 patch tokens plus one CLS token.
  localparam int N_TOK_DFLT   = 16;
  localparam int D_MODEL_DFLT = 16;
  localparam int DW_DFLT      = 8;
  localparam int CLS_ROW_DFLT = 15;

  // One signed Q4.4 element and its representable extremes.
  typedef logic signed [7:0] q44_t;

  localparam q44_t Q4_4_MAX = 8'sh7F;
  localparam q44_t Q4_4_MIN = 8'sh80;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

endpackage : ecg_pkg

// File: rtl/token_pos_embed_streamer_sat_add.sv
// Combinational signed add with clamping to the DW-bit two's-complement range.
// sat goes high whenever the true sum does not fit and had to be clamped.
module sat_add_q44
  import ecg_pkg::*;
#(
  parameter int DW = DW_DFLT
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] sum,
  output logic                 sat
);

  // Largest and smallest values representable in DW signed bits.
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW:0] wide_s;

  // Sign-extend both operands by one bit, add, and clamp on overflow.
  // Overflow shows as disagreement between the top two bits of the wide sum.
  always_comb begin
    wide_s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    sum    = wide_s[DW-1:0];
    sat    = 1'b0;
    if (wide_s[DW] != wide_s[DW-1]) begin
      sat = 1'b1;
      if (wide_s[DW]) begin
        sum = MIN_V;
      end else begin
        sum = MAX_V;
      end
    end else begin
      sat = 1'b0;
      sum = wide_s[DW-1:0];
    end
  end

endmodule : sat_add_q44

// File: rtl/token_pos_embed_streamer.sv
// Captures one token matrix on emb_done, adds the positional embedding with
// saturation and streams one token row per valid/ready handshake. The CLS row
// goes out first as position 0, followed by patch rows 0..N_TOK-2.
module token_pos_embed_streamer
  import ecg_pkg::*;
#(
  parameter int N_TOK   = N_TOK_DFLT,
  parameter int D_MODEL = D_MODEL_DFLT,
  parameter int DW      = DW_DFLT,
  parameter int CLS_ROW = CLS_ROW_DFLT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DW-1:0]        emb_matrix [N_TOK][D_MODEL],
  input  logic                        emb_done,
  input  logic signed [DW-1:0]        pos_emb    [N_TOK][D_MODEL],
  output logic signed [DW-1:0]        tok_data   [D_MODEL],
  output logic                        tok_valid,
  input  logic                        tok_ready,
  output logic [$clog2(N_TOK)-1:0]    tok_idx,
  output logic                        tok_last,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        overrun
);

  localparam int IW = $clog2(N_TOK);
  localparam logic [IW-1:0] LAST_POS = IW'(N_TOK - 1);
  localparam logic [IW-1:0] CLS_IDX  = IW'(CLS_ROW);

  stream_state_t state_r;
  stream_state_t state_nxt_s;

  logic signed [DW-1:0] buf_r      [N_TOK][D_MODEL];
  logic signed [DW-1:0] tok_data_r [D_MODEL];
  logic signed [DW-1:0] lane_sum_s [D_MODEL];
  logic [D_MODEL-1:0]   lane_sat_s;

  logic [IW-1:0] tok_idx_r;
  logic [IW-1:0] sel_pos_s;
  logic [IW-1:0] src_row_s;

  logic tok_valid_r;
  logic tok_last_r;
  logic frame_done_r;
  logic busy_r;
  logic sat_flag_r;
  logic overrun_r;

  logic hs_s;
  logic capture_s;
  logic load_s;
  logic finish_s;

  // State register; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    finish_s    = 1'b0;
    hs_s        = tok_valid_r & tok_ready;
    case (state_r)
      IDLE: begin
        if (emb_done) begin
          capture_s   = 1'b1;
          state_nxt_s = CAPT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CAPT: begin
        load_s      = 1'b1;
        state_nxt_s = STREAM;
      end
      STREAM: begin
        if (hs_s) begin
          if (tok_idx_r == LAST_POS) begin
            finish_s    = 1'b1;
            state_nxt_s = DONE;
          end else begin
            load_s      = 1'b1;
            state_nxt_s = STREAM;
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pick the output position to compute next and the buffer row feeding it.
  // Position 0 is always the CLS row; position p>0 maps to patch row p-1.
  always_comb begin
    sel_pos_s = '0;
    src_row_s = CLS_IDX;
    if (state_r == CAPT) begin
      sel_pos_s = '0;
    end else begin
      sel_pos_s = tok_idx_r + IW'(1);
    end
    if (sel_pos_s == '0) begin
      src_row_s = CLS_IDX;
    end else begin
      src_row_s = sel_pos_s - IW'(1);
    end
  end

  // One saturating adder per element lane on the selected row.
  for (genvar k = 0; k < D_MODEL; k++) begin : g_lane
    sat_add_q44 #(
      .DW (DW)
    ) u_sat_add (
      .a   (buf_r[src_row_s][k]),
      .b   (pos_emb[sel_pos_s][k]),
      .sum (lane_sum_s[k]),
      .sat (lane_sat_s[k])
    );
  end

  // Capture buffer: written only when a frame is accepted from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_TOK; r++) begin
        for (int k = 0; k < D_MODEL; k++) begin
          buf_r[r][k] <= '0;
        end
      end
    end else if (capture_s) begin
      buf_r <= emb_matrix;
    end else begin
      buf_r <= buf_r;
    end
  end

  // Output token registers; they hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D_MODEL; k++) begin
        tok_data_r[k] <= '0;
      end
      tok_idx_r   <= '0;
      tok_valid_r <= 1'b0;
      tok_last_r  <= 1'b0;
    end else if (load_s) begin
      tok_data_r  <= lane_sum_s;
      tok_idx_r   <= sel_pos_s;
      tok_valid_r <= 1'b1;
      tok_last_r  <= (sel_pos_s == LAST_POS);
    end else if (finish_s) begin
      tok_valid_r <= 1'b0;
      tok_last_r  <= 1'b0;
    end else begin
      tok_valid_r <= tok_valid_r;
      tok_last_r  <= tok_last_r;
    end
  end

  // Frame status: done pulse in the DONE cycle, busy whenever not IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= finish_s;
      busy_r       <= (state_nxt_s != IDLE);
    end
  end

  // Saturation flag: cleared by a new capture, set by any clamped lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_r <= 1'b0;
    end else if (capture_s) begin
      sat_flag_r <= 1'b0;
    end else if (load_s && (|lane_sat_s)) begin
      sat_flag_r <= 1'b1;
    end else begin
      sat_flag_r <= sat_flag_r;
    end
  end

  // Overrun: sticky record of a frame offered while the streamer was busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (emb_done && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign tok_data   = tok_data_r;
  assign tok_idx    = tok_idx_r;
  assign tok_valid  = tok_valid_r;
  assign tok_last   = tok_last_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;
  assign sat_flag   = sat_flag_r;
  assign overrun    = overrun_r;

endmodule : token_pos_embed_streamer
